// File: rtl/edge_capture_bank.sv
// Multi-channel edge capture bank: each channel synchronises an async trigger,
// detects a selectable edge and latches its data word until acknowledged.
module edge_capture_bank #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       trig,
  input  logic [1:0]                mode,
  input  logic [CHANNELS*WIDTH-1:0] d,
  input  logic [CHANNELS-1:0]       ack,
  output logic [CHANNELS*WIDTH-1:0] r,
  output logic [CHANNELS-1:0]       pulse,
  output logic [CHANNELS-1:0]       valid,
  output logic [CHANNELS-1:0]       ovf,
  output logic [CHANNELS*CNT_W-1:0] cnt
);

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } mode_e;

  logic [SYNC_STAGES-1:0] sync_q [CHANNELS];
  logic [CHANNELS-1:0]    hist_q;
  logic [CHANNELS-1:0]    pulse_q, pulse_d;
  logic [CHANNELS-1:0]    valid_q, valid_d;
  logic [CHANNELS-1:0]    ovf_q, ovf_d;
  logic [WIDTH-1:0]       r_q [CHANNELS];
  logic [WIDTH-1:0]       r_d [CHANNELS];
  logic [CNT_W-1:0]       cnt_q [CHANNELS];
  logic [CNT_W-1:0]       cnt_d [CHANNELS];
  logic [CHANNELS-1:0]    s_last, rise, fall, hit;
  mode_e                  mode_sel;

  assign mode_sel = mode_e'(mode);

  always_comb begin
    s_last  = '0;
    rise    = '0;
    fall    = '0;
    hit     = '0;
    pulse_d = '0;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      r_d[i]   = r_q[i];
      cnt_d[i] = cnt_q[i];
      s_last[i] = sync_q[i][SYNC_STAGES-1];
      rise[i]   = s_last[i] & ~hist_q[i];
      fall[i]   = ~s_last[i] & hist_q[i];
      unique case (mode_sel)
        MODE_RISE: hit[i] = rise[i];
        MODE_FALL: hit[i] = fall[i];
        MODE_BOTH: hit[i] = rise[i] | fall[i];
        default:   hit[i] = 1'b0;
      endcase
      if (hit[i]) begin
        // Capture beats a same-cycle ack; the ack still counts as consuming the
        // old word, so overrun is only raised when an unacked word is replaced.
        r_d[i]     = d[i*WIDTH +: WIDTH];
        pulse_d[i] = 1'b1;
        valid_d[i] = 1'b1;
        ovf_d[i]   = ack[i] ? 1'b0 : (ovf_q[i] | valid_q[i]);
        cnt_d[i]   = (cnt_q[i] == '1) ? cnt_q[i] : cnt_q[i] + CNT_W'(1);
      end else if (ack[i] && valid_q[i]) begin
        valid_d[i] = 1'b0;
        ovf_d[i]   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q  <= '0;
      pulse_q <= '0;
      valid_q <= '0;
      ovf_q   <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        sync_q[i] <= '0;
        r_q[i]    <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      hist_q  <= s_last;
      pulse_q <= pulse_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], trig[i]};
        r_q[i]    <= r_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
    end
  end

  always_comb begin
    r   = '0;
    cnt = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      r[i*WIDTH +: WIDTH]   = r_q[i];
      cnt[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end

  assign pulse = pulse_q;
  assign valid = valid_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_edge_capture_bank.sv
// Scoreboard bench for edge_capture_bank: expected captures are queued by the
// stimulus and consumed by a monitor whenever a channel pulses.
module tb_edge_capture_bank;

  localparam int unsigned W   = 32;
  localparam int unsigned CH  = 4;
  localparam int unsigned SS  = 2;
  localparam int unsigned CW  = 4;

  logic            clk;
  logic            rst_n;
  logic [CH-1:0]   trig;
  logic [1:0]      mode;
  logic [CH*W-1:0] d;
  logic [CH-1:0]   ack;
  logic [CH*W-1:0] r;
  logic [CH-1:0]   pulse;
  logic [CH-1:0]   valid;
  logic [CH-1:0]   ovf;
  logic [CH*CW-1:0] cnt;

  edge_capture_bank #(
    .WIDTH(W), .CHANNELS(CH), .SYNC_STAGES(SS), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .trig(trig), .mode(mode), .d(d), .ack(ack),
    .r(r), .pulse(pulse), .valid(valid), .ovf(ovf), .cnt(cnt)
  );

  typedef struct {
    logic [W-1:0]  r;
    logic          ovf;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t q [CH][$];
  int   total = 0;
  int   bad   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int ch, input logic [W-1:0] rv, input logic ov, input logic [CW-1:0] cv);
    exp_t e;
    e.r = rv; e.ovf = ov; e.cnt = cv;
    q[ch].push_back(e);
  endtask

  task automatic set_d(input int ch, input logic [W-1:0] v);
    d[ch*W +: W] = v;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, " r"},     r,     '0);
    chk({nm, " pulse"}, pulse, '0);
    chk({nm, " valid"}, valid, '0);
    chk({nm, " ovf"},   ovf,   '0);
    chk({nm, " cnt"},   cnt,   '0);
  endtask

  // Monitor: every pulse must match the oldest queued expectation for its channel.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int c = 0; c < CH; c++) begin
          if (pulse[c]) begin
            if (q[c].size() == 0) begin
              chk($sformatf("unexpected pulse ch%0d", c), 1, 0);
            end else begin
              e = q[c].pop_front();
              chk($sformatf("cap r ch%0d", c),     r[c*W +: W],    e.r);
              chk($sformatf("cap valid ch%0d", c), valid[c],       1'b1);
              chk($sformatf("cap ovf ch%0d", c),   ovf[c],         e.ovf);
              chk($sformatf("cap cnt ch%0d", c),   cnt[c*CW +: CW], e.cnt);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1; trig = '0; mode = 2'b00; d = '0; ack = '0;
    #1 rst_n = 1'b0;
    #2 check_all_zero("reset");
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    wait_cyc(2);

    // Rising capture on ch0; the later falling edge must not capture.
    mode = 2'b01;
    set_d(0, 32'h3);
    push(0, 32'h3, 1'b0, 4'd1);
    trig[0] = 1'b1;
    wait_cyc(5);
    chk("t1 valid0", valid[0], 1'b1);
    trig[0] = 1'b0;
    wait_cyc(5);
    chk("t1 cnt0 after fall", cnt[0*CW +: CW], 4'd1);

    // Both edges on ch1, then off mode, then 00->01 with trig held high.
    mode = 2'b11;
    set_d(1, 32'h7);
    push(1, 32'h7, 1'b0, 4'd1);
    trig[1] = 1'b1;
    wait_cyc(5);
    set_d(1, 32'h8);
    push(1, 32'h8, 1'b1, 4'd2);
    trig[1] = 1'b0;
    wait_cyc(5);
    ack[1] = 1'b1;
    wait_cyc(1);
    ack[1] = 1'b0;
    chk("t2 valid1 after ack", valid[1], 1'b0);
    chk("t2 ovf1 after ack", ovf[1], 1'b0);
    mode = 2'b00;
    trig[1] = 1'b1; wait_cyc(5);
    trig[1] = 1'b0; wait_cyc(5);
    trig[1] = 1'b1; wait_cyc(5);
    mode = 2'b01;   wait_cyc(5);
    chk("t2 cnt1 after mode switch", cnt[1*CW +: CW], 4'd2);
    trig[1] = 1'b0; wait_cyc(5);
    chk("t2 cnt1 after fall in rise mode", cnt[1*CW +: CW], 4'd2);

    // Overrun on ch2 and its clearing ack.
    set_d(2, 32'd10);
    push(2, 32'd10, 1'b0, 4'd1);
    trig[2] = 1'b1; wait_cyc(5);
    trig[2] = 1'b0; wait_cyc(5);
    set_d(2, 32'd11);
    push(2, 32'd11, 1'b1, 4'd2);
    trig[2] = 1'b1; wait_cyc(5);
    chk("t3 r2", r[2*W +: W], 32'd11);
    chk("t3 valid2", valid[2], 1'b1);
    chk("t3 ovf2", ovf[2], 1'b1);
    ack[2] = 1'b1;
    wait_cyc(1);
    ack[2] = 1'b0;
    chk("t3 valid2 after ack", valid[2], 1'b0);
    chk("t3 ovf2 after ack", ovf[2], 1'b0);
    chk("t3 r2 kept", r[2*W +: W], 32'd11);
    trig[2] = 1'b0;

    // Ch3: build an overrun, then hit and ack on the same posedge.
    set_d(3, 32'd4);
    push(3, 32'd4, 1'b0, 4'd1);
    trig[3] = 1'b1; wait_cyc(5);
    trig[3] = 1'b0; wait_cyc(5);
    set_d(3, 32'd9);
    push(3, 32'd9, 1'b1, 4'd2);
    trig[3] = 1'b1; wait_cyc(5);
    trig[3] = 1'b0; wait_cyc(5);
    set_d(3, 32'd5);
    push(3, 32'd5, 1'b0, 4'd3);
    trig[3] = 1'b1;
    wait_cyc(2);
    ack[3] = 1'b1;
    wait_cyc(1);
    ack[3] = 1'b0;
    wait_cyc(2);
    chk("t4 valid3", valid[3], 1'b1);

    // Saturation: 20 more rising edges on ch0 (valid0 still set, so each overruns).
    for (int i = 0; i < 20; i++) begin
      set_d(0, 32'(100 + i));
      push(0, 32'(100 + i), 1'b1, CW'((i + 2 > 15) ? 15 : i + 2));
      trig[0] = 1'b1; wait_cyc(4);
      trig[0] = 1'b0; wait_cyc(3);
    end
    chk("t5 cnt0 saturated", cnt[0*CW +: CW], 4'd15);

    // Reset mid-capture on ch1, trig0 held high across release.
    set_d(1, 32'hAA);
    trig[1] = 1'b1;
    wait_cyc(1);
    #1 rst_n = 1'b0;
    #1 check_all_zero("t6 async reset");
    trig = 4'b0001;
    mode = 2'b01;
    wait_cyc(3);
    check_all_zero("t6 held reset");
    set_d(0, 32'h66);
    push(0, 32'h66, 1'b0, 4'd1);
    rst_n = 1'b1;
    wait_cyc(8);
    chk("t6 cnt0 single capture", cnt[0*CW +: CW], 4'd1);
    chk("t6 cnt1 no capture", cnt[1*CW +: CW], 4'd0);

    for (int c = 0; c < CH; c++)
      chk($sformatf("pending captures ch%0d", c), q[c].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/edge_capture_bank.md
Name: edge_capture_bank

Overview:
- Multi-channel successor to the pulse-triggered register.
- Each channel synchronises an asynchronous trigger and detects a selectable edge on it with a clean one-cycle pulse, replacing gate-delay pulse generation.
- On each detected edge the channel captures its data word and flags it valid until acknowledged.
- Overrun is flagged and captures are counted per channel; the block sits between external event sources and a register-read/acknowledge consumer.

Parameters:
- WIDTH, 32, data bits per channel.
- CHANNELS, 4, number of independent capture channels.
- SYNC_STAGES, 2, trigger synchroniser depth (legal range 2..4).
- CNT_W, 8, width of each per-channel saturating capture counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- trig  input  CHANNELS  asynchronous trigger, one bit per channel.
- mode  input  2  edge select, all channels: 00 off, 01 rising, 10 falling, 11 both.
- d  input  CHANNELS*WIDTH  data to capture; channel i occupies d[i*WIDTH +: WIDTH].
- ack  input  CHANNELS  consumer acknowledge, one bit per channel.
- r  output  CHANNELS*WIDTH  captured data, packed the same way as d.
- pulse  output  CHANNELS  one-cycle capture strobe.
- valid  output  CHANNELS  capture pending, not yet acknowledged.
- ovf  output  CHANNELS  sticky overrun flag.
- cnt  output  CHANNELS*CNT_W  saturating capture count per channel.

Behaviour:
- Reset (rst_n=0, asynchronous): all synchroniser flops, edge-history flops, r, pulse, valid, ovf and cnt go to 0 immediately and hold 0 while rst_n=0.
- Synchroniser: per channel, a SYNC_STAGES-deep flop chain, then one history flop.
  - The edge term compares the last sync stage (s) with the history flop (h).
  - rise = s & ~h; fall = ~s & h.
  - The history flop updates every cycle regardless of mode, so a mode change never creates a false edge.
- Edge qualify:
  - hit = (mode==01 & rise) | (mode==10 & fall) | (mode==11 & (rise|fall)).
  - mode 00 never produces a hit.
- Latency: trig is first sampled high/low at posedge n. The capture posedge is n+SYNC_STAGES. At that posedge:
  - r_i <= d_i, sampled at that same posedge;
  - pulse_i <= 1;
  - valid_i <= 1;
  - cnt_i increments.
- pulse_i is high for exactly one cycle per hit, and is 0 in every other cycle.
- Ack:
  - ack_i=1 while valid_i=1 clears valid_i and ovf_i at the next posedge.
  - ack_i while valid_i=0 has no effect.
- Overrun: a hit while valid_i=1 and ack_i=0 overwrites r_i (newest data wins), keeps valid_i=1 and sets ovf_i. ovf_i stays 1 until acknowledged.
- Simultaneous hit and ack on the same posedge:
  - capture wins: r_i <= d_i and valid_i stays 1;
  - ovf_i clears, because the prior data was consumed;
  - cnt_i increments.
- Counter:
  - cnt_i saturates at 2^CNT_W-1 and does not wrap;
  - cnt_i is cleared only by reset.
- Trig held high across reset release: s and h start at 0, so the first propagated 1 is a rising edge. In mode 01 or 11 this produces exactly one capture, SYNC_STAGES+1 posedges after release at most.
- Trig pulses shorter than one clock period may be lost; there is no requirement to catch them.
- Trig toggling every cycle in mode 11 produces a hit every cycle.
- Channels are fully independent. No arbitration; any number of channels may capture on the same edge.
- Reset asserted mid-capture: all outputs are 0 asynchronously. No capture completes after release unless a new edge is seen as described above.

Test Plan:
1. Rising capture: mode=01, d0=32'h00000003, trig0 rises just before posedge 5 -> at posedge 7 r0=3, pulse0=1 for one cycle, valid0=1, cnt0=1; trig0 falls later -> no capture.
2. Both-edge and off modes: mode=11 -> trig1 rise then fall gives cnt1=2 with two separate single-cycle pulses; mode=00 -> trig1 toggle gives no pulse and cnt1 unchanged. Switching mode 00->01 while trig1 is held high gives no capture.
3. Overrun: ch2 captures d=10 without ack, then captures d=11 -> r2=11, valid2=1, ovf2=1. Ack2 for one cycle -> valid2=0 and ovf2=0 at the next posedge.
4. Simultaneous: ack3 asserted on the same posedge as a ch3 hit with d=5 -> r3=5, valid3=1, ovf3=0, cnt3 incremented.
5. Saturation: with CNT_W=4, drive 20 rising edges on ch0 -> cnt0 stops at 15.
6. Reset: trig0=1 held through reset, rst_n asserted mid-run -> all outputs 0 immediately. After release with mode=01 -> exactly one capture on ch0 and no further pulses while trig0 stays high.
